// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and line idle level.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE = 1'b1;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input uart_parity_t mode);
        logic par;
        par = ^data;
        if (mode == PAR_ODD) begin
            par = ~par;
        end else if (mode == PAR_NONE) begin
            par = 1'b0;
        end
        return par;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses o_bit_done on the last count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                            clock,
    input  logic                            i_reset_n,
    input  logic                            i_restart,
    output logic [$clog2(CLKS_PER_BIT)-1:0] o_count,
    output logic                            o_bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_restart || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_count    = count;
    assign o_bit_done = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, serial frame out (start, LSB-first data,
// optional parity, stop). All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam uart_parity_t PAR_MODE = uart_parity_t'(PARITY);
    localparam logic [CNT_W-1:0] PRE_LAST_COUNT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_tx: DATA_BITS must be in 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       state, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic                 stop_cnt, stop_next;
    logic                 par_bit, par_next;
    logic                 tx_reg, tx_next;
    logic                 ready_reg, ready_next;
    logic                 busy_reg, busy_next;
    logic [CNT_W-1:0]     bit_count;
    logic                 bit_done;
    logic                 handshake;

    assign handshake = i_valid && ready_reg;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .i_restart (handshake),
        .o_count   (bit_count),
        .o_bit_done(bit_done)
    );

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            tx_reg    <= UART_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= idx_next;
            stop_cnt  <= stop_next;
            par_bit   <= par_next;
            tx_reg    <= tx_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        idx_next   = bit_idx;
        stop_next  = stop_cnt;
        par_next   = par_bit;

        case (state)
            ST_IDLE: ;
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_next  = 1'b0;
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                    stop_next  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        stop_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // ready_reg is only high in IDLE or the last stop cycle, so a handshake
        // here always starts a new frame, including the back-to-back case.
        if (handshake) begin
            state_next = ST_START;
            shift_next = i_data;
            par_next   = calc_parity(8'(i_data), PAR_MODE);
        end

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = par_next;
            default:   tx_next = UART_IDLE;
        endcase

        busy_next  = (state_next != ST_IDLE);
        ready_next = (state_next == ST_IDLE) ||
                     ((state == ST_STOP) && (stop_cnt == STOP_LAST) &&
                      (bit_count == PRE_LAST_COUNT));
    end

    assign o_tx    = tx_reg;
    assign o_ready = ready_reg;
    assign o_busy  = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench: four uart_tx configurations compared every cycle against a
// frame-level model, plus literal checks of the directed scenarios.
module tb_uart_tx;

    localparam int CLKS = 4;
    localparam int NI   = 4;
    localparam int DB [NI] = '{8, 8, 8, 7};
    localparam int PB [NI] = '{0, 1, 2, 0};
    localparam int SB [NI] = '{1, 1, 1, 2};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] valid = '0;
    logic [7:0]    data [NI];
    logic [NI-1:0] ready;
    logic [NI-1:0] tx;
    logic [NI-1:0] busy;

    int        vectors     = 0;
    int        miscompares = 0;
    bit        chk_en      = 1'b0;
    int        pos [NI]    = '{-1, -1, -1, -1};
    logic [15:0] fbits [NI];
    logic      e_tx, e_ready, e_busy;
    logic [15:0] slots;
    int        len;
    int        c;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(CLKS),
            .DATA_BITS   (DB[g]),
            .PARITY      (PB[g]),
            .STOP_BITS   (SB[g])
        ) u_dut (
            .clock    (clk),
            .i_reset_n(rst_n),
            .i_valid  (valid[g]),
            .i_data   (data[g][DB[g]-1:0]),
            .o_ready  (ready[g]),
            .o_tx     (tx[g]),
            .o_busy   (busy[g])
        );
    end

    function automatic int flen(input int k);
        return (1 + DB[k] + ((PB[k] != 0) ? 1 : 0) + SB[k]) * CLKS;
    endfunction

    // Slot i of the returned vector is the line level during bit time i of the frame.
    function automatic logic [15:0] make_frame(input int k, input logic [7:0] d);
        logic [15:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < DB[k]; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (PB[k] == 1) f[1 + DB[k]] = ((ones % 2) == 1);
        if (PB[k] == 2) f[1 + DB[k]] = ((ones % 2) == 0);
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) pos[k] = -1;
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (valid[k] && (pos[k] < 0 || pos[k] == flen(k) - 1)) begin
                    fbits[k] = make_frame(k, data[k]);
                    pos[k]   = 0;
                end else if (pos[k] >= 0) begin
                    pos[k]++;
                    if (pos[k] == flen(k)) pos[k] = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                e_tx    = (pos[k] < 0) ? 1'b1 : fbits[k][pos[k] / CLKS];
                e_ready = (pos[k] < 0) || (pos[k] == flen(k) - 1);
                e_busy  = (pos[k] >= 0);
                checkOutput($sformatf("tx%0d", k), 32'(tx[k]), 32'(e_tx));
                checkOutput($sformatf("ready%0d", k), 32'(ready[k]), 32'(e_ready));
                checkOutput($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy));
            end
        end
    end

    // Sends one word on instance k and samples each bit slot mid-period; len is the
    // cycle (counted from the first start-bit cycle as 1) where ready returns, 0 on timeout.
    task automatic applyStimulus(input int k, input logic [7:0] d, input bit disturb,
                                 output logic [15:0] cap, output int flength);
        valid[k] = 1'b1;
        data[k]  = d;
        @(posedge clk); #1;
        valid[k] = 1'b0;
        cap      = '0;
        flength  = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (disturb && cyc == 10) begin
                data[k]  = ~d;
                valid[k] = 1'b1;
            end
            if (disturb && cyc == 11) valid[k] = 1'b0;
            if ((cyc % CLKS) == 1) cap[cyc / CLKS] = tx[k];
            if (ready[k]) begin
                flength = cyc + 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) data[k] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("reset tx%0d", k), 32'(tx[k]), 32'd1);
            checkOutput($sformatf("reset ready%0d", k), 32'(ready[k]), 32'd1);
            checkOutput($sformatf("reset busy%0d", k), 32'(busy[k]), 32'd0);
        end
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk); #1;

        repeat (600) begin
            for (int k = 0; k < NI; k++) begin
                valid[k] = ($urandom_range(0, 3) == 0);
                data[k]  = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        valid = '0;
        repeat (60) @(posedge clk);
        #1;

        applyStimulus(0, 8'h55, 1'b0, slots, len);
        checkOutput("8N1 0x55 slots", 32'(slots[9:0]), 32'h2AA);
        checkOutput("8N1 0x55 length", len, 40);

        applyStimulus(1, 8'h07, 1'b0, slots, len);
        checkOutput("8E1 0x07 slots", 32'(slots[10:0]), 32'h60E);
        checkOutput("8E1 0x07 length", len, 44);

        applyStimulus(2, 8'h00, 1'b0, slots, len);
        checkOutput("8O1 0x00 parity slot", 32'(slots[9]), 32'd1);
        checkOutput("8O1 0x00 length", len, 44);

        applyStimulus(3, 8'h7F, 1'b0, slots, len);
        checkOutput("7N2 0x7F slots", 32'(slots[9:0]), 32'h3FE);
        checkOutput("7N2 0x7F length", len, 40);

        applyStimulus(0, 8'h55, 1'b1, slots, len);
        checkOutput("disturbed slots", 32'(slots[9:0]), 32'h2AA);
        checkOutput("disturbed length", len, 40);
        @(posedge clk); #1;
        checkOutput("no second frame busy", 32'(busy[0]), 32'd0);

        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        @(posedge clk); #1;
        data[0] = 8'h3C;
        c = 0;
        while (!ready[0] && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("b2b first ready cycle", c, 39);
        @(posedge clk); #1;
        valid[0] = 1'b0;
        c++;
        checkOutput("b2b second start bit", 32'(tx[0]), 32'd0);
        while (!ready[0] && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("b2b second ready cycle", c, 79);
        @(posedge clk); #1;

        valid[0] = 1'b1;
        data[0]  = 8'h55;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset tx", 32'(tx[0]), 32'd1);
        checkOutput("async reset ready", 32'(ready[0]), 32'd1);
        checkOutput("async reset busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 8'h55, 1'b0, slots, len);
        checkOutput("post-reset slots", 32'(slots[9:0]), 32'h2AA);
        checkOutput("post-reset length", len, 40);

        repeat (5) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
